// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter for the async FIFO: shares the read port among NREQ consumers.
// Define FIFO_RD_ARB_FIXED_PRIO_EN for fixed priority (consumer 0 highest).
module fifo_rd_arbiter #(
   parameter int DSIZE     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   parameter int IDW       = $clog2(NREQ)
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  rdy,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [NREQ-1:0]  gnt,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic [IDW-1:0]   out_id,
   output logic             busy
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [7:0]     BLAST  = 8'(MAX_BURST - 1);
   localparam logic [IDW-1:0] LASTID = IDW'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE   = NREQ'(1);

   state_t         state;
   logic [IDW-1:0] g_idx;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] nxt_ptr;
   logic [IDW-1:0] sel_idx;
   logic [7:0]     bcnt;
   logic           sel_vld;
   logic           req_g;
   logic           rdy_o;
   logic           accept;
   logic           pop;
   logic           last_word;
   logic           burst_end;

   assign req_g     = req[g_idx];
   assign rdy_o     = rdy[out_id];
   assign accept    = out_valid & rdy_o;
   assign pop       = (state == BURST) & req_g & ~rempty
                    & (~out_valid | accept);
   assign rinc      = pop;
   assign busy      = (state == BURST);
   assign last_word = (bcnt == BLAST);
   assign burst_end = (pop & last_word) | ~req_g;
   assign nxt_ptr   = (g_idx == LASTID) ? '0 : g_idx + 1'b1;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
   // Scan downward so the lowest set index wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            sel_vld = 1'b1;
            sel_idx = IDW'(k);
         end
      end
   end
`else
   // First requester at or above rr_ptr, wrapping at NREQ.
   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!sel_vld && req[IDW'(idx)]) begin
            sel_vld = 1'b1;
            sel_idx = IDW'(idx);
         end
      end
   end
`endif

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         g_idx     <= '0;
         rr_ptr    <= '0;
         bcnt      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (sel_vld) begin
                  gnt   <= ONE << sel_idx;
                  g_idx <= sel_idx;
                  bcnt  <= '0;
                  state <= BURST;
               end
            end
            BURST: begin
               if (burst_end) begin
                  state <= IDLE;
                  gnt   <= '0;
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
                  rr_ptr <= '0;
`else
                  rr_ptr <= nxt_ptr;
`endif
               end else if (pop) begin
                  bcnt <= bcnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // A pop overwrites the held word; its accept completes the same edge.
         if (pop) begin
            out_data  <= rdata;
            out_id    <= g_idx;
            out_valid <= 1'b1;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter with a small FIFO model on the read port.
module tb_fifo_rd_arbiter;

   logic       rclk;
   logic       rrst_n;
   logic [3:0] req;
   logic [3:0] rdy;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic [3:0] gnt;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_id;
   logic       busy;

   int checks;
   int failures;

   logic [7:0] mem [0:63];
   int         wptr;
   int         rptr;
   logic [9:0] exp_q [$];
   logic [9:0] sb_e;

   fifo_rd_arbiter #(
      .DSIZE(8), .NREQ(4), .MAX_BURST(4), .IDW(2)
   ) dut (
      .rclk(rclk), .rrst_n(rrst_n), .req(req), .rdy(rdy),
      .rempty(rempty), .rdata(rdata), .rinc(rinc), .gnt(gnt),
      .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .busy(busy)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   assign rempty = (rptr == wptr);
   assign rdata  = mem[6'(rptr)];

   initial rptr = 0;
   always @(posedge rclk) begin
      if (rinc) begin
         checks++;
         if (rempty) begin
            failures++;
            $display("FAIL underflow: rinc=1 while rempty=1 required rinc=0");
         end
         rptr <= rptr + 1;
      end
   end

   always @(negedge rclk) begin
      if (rrst_n && out_valid && rdy[out_id]) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: got id=%0d data=%h required none",
                     out_id, out_data);
         end else begin
            sb_e = exp_q.pop_front();
            if ({out_id, out_data} !== sb_e) begin
               failures++;
               $display("FAIL sb_word: got id=%0d data=%h required id=%0d data=%h",
                        out_id, out_data, sb_e[9:8], sb_e[7:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic put_word(input logic [7:0] d, input logic [1:0] id,
                           input bit expect_it);
      mem[6'(wptr)] = d;
      wptr = wptr + 1;
      if (expect_it) exp_q.push_back({id, d});
   endtask

   task automatic wait_busy(input logic v, input string nm);
      int n;
      n = 0;
      while (busy !== v && n < 100) begin
         tick();
         n++;
      end
      chk(nm, busy, v);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rinc", rinc, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_id", out_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rrptr", dut.rr_ptr, 0);
      chk("rst_bcnt", dut.bcnt, 0);
      tick();
      rrst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] eid;
      checks   = 0;
      failures = 0;
      wptr     = 0;
      req      = '0;
      rdy      = '0;
      rrst_n   = 1'b0;
      #2;
      do_reset();

      // single burst of 4, then re-grant for the remaining 2
      rdy = 4'b1111;
      for (int i = 0; i < 6; i++) put_word(8'hA0 + 8'(i), 2'd0, 1'b1);
      req = 4'b0001;
      tick();
      chk("t1_gnt", gnt, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         chk("t1_rinc", rinc, 1);
         tick();
      end
      chk("t1_idle_gnt", gnt, 0);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_rinc", rinc, 0);
      tick();
      chk("t1_regnt", gnt, 4'b0001);
      chk("t1_rinc4", rinc, 1);
      tick();
      chk("t1_rinc5", rinc, 1);
      tick();
      chk("t1_empty_rinc", rinc, 0);
      chk("t1_empty_gnt", gnt, 4'b0001);
      chk("t1_bcnt", dut.bcnt, 2);
      req = 4'b0000;
      tick();
      chk("t1_end_busy", busy, 0);
      drain("t1_drain");

      // round robin with all requesters active
      do_reset();
      for (int k = 0; k < 4; k++) begin
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
         eid = 2'd0;
`else
         eid = 2'(k);
`endif
         for (int i = 0; i < 4; i++)
            put_word(8'hB0 + 8'(4 * k + i), eid, 1'b1);
      end
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_busy(1'b1, "t2_busy");
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
         chk("t2_gnt", gnt, 4'b0001);
`else
         chk("t2_gnt", gnt, 4'b0001 << k);
`endif
         wait_busy(1'b0, "t2_idle");
      end
      wait_busy(1'b1, "t2_wrap_busy");
      chk("t2_wrap_gnt", gnt, 4'b0001);
      req = 4'b0000;
      wait_busy(1'b0, "t2_end");
      drain("t2_drain");

      // empty stall on consumer 2
      put_word(8'hC0, 2'd2, 1'b1);
      req = 4'b0100;
      wait_busy(1'b1, "t3_busy");
      chk("t3_gnt", gnt, 4'b0100);
      chk("t3_rinc0", rinc, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_rinc", rinc, 0);
         chk("t3_stall_gnt", gnt, 4'b0100);
         chk("t3_stall_bcnt", dut.bcnt, 1);
         tick();
      end
      put_word(8'hC1, 2'd2, 1'b1);
      #1;
      chk("t3_resume", rinc, 1);
      tick();
      chk("t3_bcnt2", dut.bcnt, 2);
      req = 4'b0000;
      wait_busy(1'b0, "t3_end");
      drain("t3_drain");

      // backpressure on consumer 3, other rdy bits high
      rdy = 4'b0111;
      put_word(8'hD0, 2'd3, 1'b1);
      put_word(8'hD1, 2'd3, 1'b1);
      put_word(8'hD2, 2'd3, 1'b1);
      req = 4'b1000;
      wait_busy(1'b1, "t4_busy");
      chk("t4_gnt", gnt, 4'b1000);
      chk("t4_rinc0", rinc, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_data", out_data, 8'hD0);
         chk("t4_hold_rinc", rinc, 0);
         tick();
      end
      rdy = 4'b1111;
      #1;
      chk("t4_acc_pop", rinc, 1);
      tick();
      chk("t4_next_data", out_data, 8'hD1);
      chk("t4_next_valid", out_valid, 1);
      tick();
      req = 4'b0000;
      wait_busy(1'b0, "t4_end");
      drain("t4_drain");

      // early release by consumer 1
      put_word(8'hE0, 2'd1, 1'b1);
      put_word(8'hE1, 2'd2, 1'b0);
      req = 4'b0010;
      wait_busy(1'b1, "t5_busy");
      chk("t5_gnt", gnt, 4'b0010);
      chk("t5_rinc", rinc, 1);
      tick();
      req = 4'b0000;
      #1;
      chk("t5_drop_rinc", rinc, 0);
      tick();
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_gnt", gnt, 0);
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      chk("t5_rrptr", dut.rr_ptr, 0);
`else
      chk("t5_rrptr", dut.rr_ptr, 2);
`endif
      drain("t5_drain");

      // reset in the middle of a burst with a held word
      rdy = 4'b0000;
      req = 4'b0100;
      wait_busy(1'b1, "t5r_busy");
      chk("t5r_gnt", gnt, 4'b0100);
      tick();
      chk("t5r_valid", out_valid, 1);
      req = 4'b0000;
      wptr = rptr;
      do_reset();

      // persistent requests from consumers 1 and 3
      rdy = 4'b1111;
      for (int b = 0; b < 3; b++) begin
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
         eid = 2'd1;
`else
         eid = (b == 1) ? 2'd3 : 2'd1;
`endif
         for (int i = 0; i < 4; i++)
            put_word(8'hF0 + 8'(4 * b + i), eid, 1'b1);
      end
      req = 4'b1010;
      for (int b = 0; b < 3; b++) begin
         wait_busy(1'b1, "t6_busy");
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
         chk("t6_gnt", gnt, 4'b0010);
`else
         chk("t6_gnt", gnt, (b == 1) ? 4'b1000 : 4'b0010);
`endif
         wait_busy(1'b0, "t6_idle");
      end
      req = 4'b0000;
      tick();
      chk("t6_stay_idle", busy, 0);
      drain("t6_drain");

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
